// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core pipeline, the arbiter and the unified memory port.
// slave  : arbiter view (takes fetch/data requests and memory read data,
//          drives readies, responses and the memory request).
// master : environment view (core pipeline + memory), the mirror image.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // fetch requester
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // load/store requester
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // memory port
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_valid, if_addr, d_valid, d_addr, d_we, d_wstrb, d_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_we, mem_wstrb, mem_wdata
  );

  modport master (
    output if_valid, if_addr, d_valid, d_addr, d_we, d_wstrb, d_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_we, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single unified memory port.
// Load/store wins by default; a saturating starvation counter forces a fetch
// through after STARVE_MAX consecutive refusals. Read data has one-cycle
// latency and is routed back using the registered owner of the previous grant.
// Ports: clk, rst (synchronous, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t            owner;
  owner_t            grant;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;
  logic [ADDR_W-1:0] addr_mux;
  logic              write;

  // Owner and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= grant;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Grant selection and next counter value
  always_comb begin
    grant          = OWN_NONE;
    starve_cnt_nxt = starve_cnt;

    if (!rst) begin
      if (bus.if_valid && bus.d_valid) begin
        grant = (starve_cnt == CNT_MAX) ? OWN_IF : OWN_D;
      end else if (bus.if_valid) begin
        grant = OWN_IF;
      end else if (bus.d_valid) begin
        grant = OWN_D;
      end
    end

    // Saturates at CNT_MAX; the cap is what forces the fetch grant above.
    if (!bus.if_valid || grant == OWN_IF) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Memory request mux
  assign write    = (grant == OWN_D) && bus.d_we;
  assign addr_mux = (grant == OWN_D) ? bus.d_addr : bus.if_addr;

  assign bus.if_ready  = (grant == OWN_IF);
  assign bus.d_ready   = (grant == OWN_D);
  assign bus.mem_en    = (grant != OWN_NONE);
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_we    = write;
  assign bus.mem_wstrb = write ? bus.d_wstrb : STRB_W'(0);
  assign bus.mem_wdata = bus.d_wdata;

  // Responses: rst masks a response still owed from the cycle before reset.
  assign bus.if_rvalid = (owner == OWN_IF) && !rst;
  assign bus.d_rvalid  = (owner == OWN_D) && !rst;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus directed
// sequences for starvation and mid-operation reset. Includes a word-addressed
// memory model with one-cycle read latency.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded while rst is high, registered read data.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (rst) begin
      mem[0]     <= 32'h0000_0013;
      mem[1]     <= 32'h0010_0093;
      mem[2]     <= 32'h0020_0113;
      mem[4]     <= 32'hAAAA_0010;
      mem[12'h800] <= 32'h1234_5678;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[13:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[13:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic        dwe;
    logic [3:0]  dstrb;
    logic [31:0] dwd;
    logic        e_ir;
    logic        e_dr;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic        e_irv;
    logic        e_drv;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic dwe, input logic [3:0] dstrb,
                       input logic [31:0] dwd);
    bus.if_valid = iv;
    bus.if_addr  = ia;
    bus.d_valid  = dv;
    bus.d_addr   = da;
    bus.d_we     = dwe;
    bus.d_wstrb  = dstrb;
    bus.d_wdata  = dwd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //                iv  ia        dv  da        we  strb  wdata          ir  dr  en  we  addr      strb  irv drv chk rdata
    vecs[0]  = '{1'b1, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h0,    4'h0, 1'b0,1'b0,1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h4,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h4,    4'h0, 1'b1,1'b0,1'b1, 32'h0000_0013};
    vecs[2]  = '{1'b1, 32'h8,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h8,    4'h0, 1'b1,1'b0,1'b1, 32'h0010_0093};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,    4'h0, 1'b1,1'b0,1'b1, 32'h0020_0113};
    vecs[4]  = '{1'b0, 32'h0,    1'b1, 32'h2000, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0,1'b1,1'b1,1'b1, 32'h2000, 4'h3, 1'b0,1'b0,1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0,1'b1,1'b1,1'b0, 32'h2000, 4'h0, 1'b0,1'b1,1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h10,   1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h10,   4'h0, 1'b0,1'b1,1'b1, 32'h1234_BEEF};
    vecs[7]  = '{1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 4'h0, 32'h0,        1'b0,1'b1,1'b1,1'b0, 32'h2000, 4'h0, 1'b1,1'b0,1'b1, 32'hAAAA_0010};
    vecs[8]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,    4'h0, 1'b0,1'b1,1'b1, 32'h1234_BEEF};
    for (int i = 9; i < 14; i++)
      vecs[i] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,    4'h0, 1'b0,1'b0,1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h4,    1'b1, 32'h2000, 1'b0, 4'h0, 32'h0,        1'b0,1'b1,1'b1,1'b0, 32'h2000, 4'h0, 1'b0,1'b0,1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,    4'h0, 1'b0,1'b1,1'b1, 32'h1234_BEEF};
    vecs[16] = '{1'b0, 32'h0,    1'b1, 32'h0,    1'b1, 4'h0, 32'hFFFFFFFF, 1'b0,1'b1,1'b1,1'b1, 32'h0,    4'h0, 1'b0,1'b0,1'b0, 32'h0};
    vecs[17] = '{1'b1, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h0,    4'h0, 1'b0,1'b1,1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,    4'h0, 1'b1,1'b0,1'b1, 32'h0000_0013};

    // Reset with both requests active: nothing may be granted
    rst = 1'b1;
    drive(1'b1, 32'h4, 1'b1, 32'h2000, 1'b1, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ready", 32'(bus.if_ready), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);

    // Vector table, one row per cycle
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dwe, vecs[i].dstrb, vecs[i].dwd);
      @(negedge clk);
      check($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_d_ready", i), 32'(bus.d_ready), 32'(vecs[i].e_dr));
      check($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_mem_wstrb", i), 32'(bus.mem_wstrb), 32'(vecs[i].e_strb));
      check($sformatf("v%0d_if_rvalid", i), 32'(bus.if_rvalid), 32'(vecs[i].e_irv));
      check($sformatf("v%0d_d_rvalid", i), 32'(bus.d_rvalid), 32'(vecs[i].e_drv));
      if (vecs[i].e_en) check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d_if_rdata", i), bus.if_rdata, vecs[i].e_rd);
        check($sformatf("v%0d_d_rdata", i), bus.d_rdata, vecs[i].e_rd);
      end
    end

    // Starvation: both requesters busy for 10 cycles -> D,D,D,D,IF repeating
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 32'h0, 1'b1, 32'h2000, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      check($sformatf("starve%0d_cnt", i), 32'(dut.starve_cnt), 32'(i % 5));
      check($sformatf("starve%0d_if_ready", i), 32'(bus.if_ready), 32'((i % 5) == 4));
      check($sformatf("starve%0d_d_ready", i), 32'(bus.d_ready), 32'((i % 5) != 4));
    end

    // Reset mid-transaction: build up starvation, grant a load, then reset
    @(posedge clk);
    #1;
    drive(1'b1, 32'h0, 1'b1, 32'h2000, 1'b0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_load_d_ready", 32'(bus.d_ready), 32'd1);
    check("mid_cnt_before_rst", 32'(dut.starve_cnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 32'h2000, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    check("mid_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mid_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_readies", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("mid_rst2_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_rst2_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("post_rst_cnt", 32'(dut.starve_cnt), 32'd0);
    check("post_rst_if_ready", 32'(bus.if_ready), 32'd1);
    check("post_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("post_rst_if_rdata", bus.if_rdata, 32'h0020_0113);
    check("post_rst_d_rvalid2", 32'(bus.d_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
